// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage:
// load-op encodings and WB state encoding.
package cpu_defs;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LBU  = 3'd2;
  localparam logic [2:0] LOAD_LH   = 3'd3;
  localparam logic [2:0] LOAD_LHU  = 3'd4;
  localparam logic [2:0] LOAD_LW   = 3'd5;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_HOLD  = 2'd1,
    WB_WAIT  = 2'd2
  } wb_state_e;

  function automatic logic is_load(logic [2:0] op);
    return (op >= LOAD_LB) && (op <= LOAD_LW);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB valid/allowin handshake and
// retiring-instruction payload.
interface mem_wb_if;
  logic        mem_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic [2:0]  mem_load_op;

  modport master (
    output mem_valid, mem_pc, mem_wen,
    output mem_waddr, mem_result, mem_load_op,
    input  wb_allowin
  );

  modport slave (
    input  mem_valid, mem_pc, mem_wen,
    input  mem_waddr, mem_result, mem_load_op,
    output wb_allowin
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment and sign/zero extension.
// Non-load ops pass the ALU result through.
module load_align
  import cpu_defs::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16]
                          : rdata[15:0];
    wdata = result;
    unique case (load_op)
      LOAD_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: wdata = {24'd0, byte_sel};
      LOAD_LH:  wdata = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: wdata = {16'd0, half_sel};
      LOAD_LW:  wdata = rdata;
      default:  wdata = result;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: holds the retiring instruction, waits
// for load data, drives RF write, bypass and debug trace.
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_wb_if.slave                 mem,
  input  logic [31:0]             data_rdata,
  input  logic                    data_rdata_valid,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    fwd_valid,
  output logic [4:0]              fwd_waddr,
  output logic [31:0]             fwd_wdata,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  wb_state_e   state;
  logic [31:0] pc_q;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] result_q;
  logic [2:0]  op_q;
  logic        ready_go;
  logic        accept;
  logic        wr_ok;
  logic [31:0] wdata;

  assign ready_go = (state == WB_HOLD) ||
                    ((state == WB_WAIT) && data_rdata_valid);
  assign mem.wb_allowin = (state == WB_EMPTY) || ready_go;
  assign accept = mem.mem_valid && mem.wb_allowin;
  assign wr_ok = wen_q && (waddr_q != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WB_EMPTY;
      pc_q       <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      result_q   <= '0;
      op_q       <= LOAD_NONE;
      retire_cnt <= '0;
    end else begin
      if (accept) begin
        state    <= is_load(mem.mem_load_op) ? WB_WAIT
                                             : WB_HOLD;
        pc_q     <= mem.mem_pc;
        wen_q    <= mem.mem_wen;
        waddr_q  <= mem.mem_waddr;
        result_q <= mem.mem_result;
        op_q     <= mem.mem_load_op;
      end else if (ready_go) begin
        state <= WB_EMPTY;
      end
      if (ready_go)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

  // addr_lo is the low bits of the latched effective address
  load_align u_align (
    .load_op (op_q),
    .addr_lo (result_q[1:0]),
    .rdata   (data_rdata),
    .result  (result_q),
    .wdata   (wdata)
  );

  assign rf_we    = ready_go && wr_ok;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata;

  assign fwd_valid = (state != WB_EMPTY) && wr_ok;
  assign fwd_waddr = waddr_q;
  assign fwd_wdata = wdata;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random
// traffic against a queue-based occupancy model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_rdata;
  logic        data_rdata_valid;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, fwd_wdata, debug_wb_pc;
  logic [31:0] debug_wb_rf_wdata, retire_cnt;
  logic [3:0]  debug_wb_rf_wen;

  int tests = 0;
  int fails = 0;

  mem_wb_if bus ();

  mem_wb_stage #(.RETIRE_CNT_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem               (bus.slave),
    .data_rdata        (data_rdata),
    .data_rdata_valid  (data_rdata_valid),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_waddr         (fwd_waddr),
    .fwd_wdata         (fwd_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_cnt        (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [2:0]  op;
  } ins_t;

  ins_t        occ[$];
  logic [31:0] cnt;
  logic        m_rg, m_allow;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Architectural load semantics via plain shifts/arithmetic
  function automatic logic [31:0] ref_val(
      logic [2:0] op, logic [31:0] rd, logic [31:0] res);
    int unsigned a, b, h;
    a = res & 3;
    b = (rd >> (8 * a)) & 255;
    h = (rd >> (16 * (a / 2))) & 65535;
    case (op)
      3'd1: return (b >= 128) ? b - 256 : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? h - 65536 : h;
      3'd4: return h;
      3'd5: return rd;
      default: return res;
    endcase
  endfunction

  task automatic drive(logic mv, logic [31:0] pc,
                       logic wen, logic [4:0] wa,
                       logic [31:0] res, logic [2:0] op,
                       logic dv, logic [31:0] rd);
    @(negedge clk);
    bus.mem_valid   = mv;
    bus.mem_pc      = pc;
    bus.mem_wen     = wen;
    bus.mem_waddr   = wa;
    bus.mem_result  = res;
    bus.mem_load_op = op;
    data_rdata_valid = dv;
    data_rdata       = rd;
    #1;
  endtask

  task automatic check_model();
    ins_t h;
    logic has, ld, ewe, efw;
    has = (occ.size() != 0);
    h = '{32'd0, 1'b0, 5'd0, 32'd0, 3'd0};
    if (has) h = occ[0];
    ld = has && (h.op >= 3'd1) && (h.op <= 3'd5);
    m_rg = has && (!ld || data_rdata_valid);
    m_allow = !has || m_rg;
    ewe = m_rg && h.wen && (h.waddr != 5'd0);
    efw = has && h.wen && (h.waddr != 5'd0);
    chk("allowin", {31'd0, bus.wb_allowin}, {31'd0, m_allow});
    chk("rf_we", {31'd0, rf_we}, {31'd0, ewe});
    chk("dbg_wen", {28'd0, debug_wb_rf_wen}, {28'd0, {4{ewe}}});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, efw});
    chk("retire_cnt", retire_cnt, cnt);
    if (has) begin
      chk("dbg_pc", debug_wb_pc, h.pc);
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, h.waddr});
      chk("fwd_waddr", {27'd0, fwd_waddr}, {27'd0, h.waddr});
      chk("dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, h.waddr});
    end
    if (m_rg) begin
      logic [31:0] ev;
      ev = ref_val(h.op, data_rdata, h.result);
      chk("rf_wdata", rf_wdata, ev);
      chk("fwd_wdata", fwd_wdata, ev);
      chk("dbg_wdata", debug_wb_rf_wdata, ev);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_rg) begin
      void'(occ.pop_front());
      cnt = cnt + 1;
    end
    if (bus.mem_valid && m_allow)
      occ.push_back('{bus.mem_pc, bus.mem_wen, bus.mem_waddr,
                      bus.mem_result, bus.mem_load_op});
  endtask

  task automatic cyc(logic mv, logic [31:0] pc, logic wen,
                     logic [4:0] wa, logic [31:0] res,
                     logic [2:0] op, logic dv,
                     logic [31:0] rd);
    drive(mv, pc, wen, wa, res, op, dv, rd);
    check_model();
  endtask

  task automatic idle(logic dv, logic [31:0] rd);
    cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, dv, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    data_rdata_valid = 1'b0;
    #1;
    occ.delete();
    cnt = 0;
    chk("rst_allowin", {31'd0, bus.wb_allowin}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_fwd_wdata", fwd_wdata, 32'd0);
    chk("rst_dbg_pc", debug_wb_pc, 32'd0);
    chk("rst_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_pc = '0;
    bus.mem_wen = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_result = '0;
    bus.mem_load_op = '0;
    data_rdata = '0;
    data_rdata_valid = 1'b0;
    cnt = 0;
    do_reset();

    // ADDU retire
    cyc(1, 32'hBFC0_0000, 1, 5, 32'h1234, 0, 0, 0); tick();
    idle(0, 0);
    chk("addu_we", {31'd0, rf_we}, 32'd1);
    chk("addu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("addu_wdata", rf_wdata, 32'h1234);
    tick();
    idle(0, 0);
    chk("addu_cnt", retire_cnt, 32'd1);
    tick();

    // write to $0 still retires
    cyc(1, 32'hBFC0_0004, 1, 0, 32'h55, 0, 0, 0); tick();
    idle(0, 0);
    chk("r0_we", {31'd0, rf_we}, 32'd0);
    chk("r0_fwd", {31'd0, fwd_valid}, 32'd0);
    tick();
    idle(0, 0);
    chk("r0_cnt", retire_cnt, 32'd2);
    tick();

    // LB / LBU with 3-cycle data latency
    for (int k = 0; k < 2; k++) begin
      cyc(1, 32'hBFC0_0010, 1, 7, 32'h1000_0003,
          (k == 0) ? 3'd1 : 3'd2, 0, 0);
      tick();
      idle(0, 0);
      chk("lb_stall1", {31'd0, bus.wb_allowin}, 32'd0);
      tick();
      idle(0, 0);
      chk("lb_stall2", {31'd0, bus.wb_allowin}, 32'd0);
      chk("lb_fwd_wait", {31'd0, fwd_valid}, 32'd1);
      tick();
      idle(1, 32'h80FF_00AA);
      chk("lb_data", rf_wdata,
          (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb_we", {31'd0, rf_we}, 32'd1);
      tick();
    end

    // LH upper half, LHU lower half
    cyc(1, 32'hBFC0_0020, 1, 8, 32'h2000_0002, 3, 0, 0);
    tick();
    idle(1, 32'h8001_7FFF);
    chk("lh_data", rf_wdata, 32'hFFFF_8001);
    tick();
    cyc(1, 32'hBFC0_0024, 1, 9, 32'h2000_0000, 4, 0, 0);
    tick();
    idle(1, 32'h8001_7FFF);
    chk("lhu_data", rf_wdata, 32'h0000_7FFF);
    tick();

    // back-to-back non-loads
    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        cyc(1, 32'hBFC0_0100 + 4 * k, 1, 5'(10 + k),
            32'(k * 3), 0, 0, 0);
      else
        idle(0, 0);
      chk("b2b_allowin", {31'd0, bus.wb_allowin}, 32'd1);
      if (k > 0)
        chk("b2b_we", {31'd0, rf_we}, 32'd1);
      tick();
    end

    // load data and next instruction in the same cycle
    cyc(1, 32'hBFC0_0200, 1, 3, 32'h3000_0000, 5, 0, 0);
    tick();
    cyc(1, 32'hBFC0_0204, 1, 4, 32'hCAFE, 0, 1, 32'hDEAD_BEEF);
    chk("ldnx_we1", {31'd0, rf_we}, 32'd1);
    chk("ldnx_data", rf_wdata, 32'hDEAD_BEEF);
    tick();
    idle(0, 0);
    chk("ldnx_we2", {31'd0, rf_we}, 32'd1);
    chk("ldnx_data2", rf_wdata, 32'hCAFE);
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  op;
      logic [31:0] ad;
      op = 3'($urandom_range(0, 7));
      ad = $urandom;
      if (op == 3'd3 || op == 3'd4) ad[0] = 1'b0;
      if (op == 3'd5) ad[1:0] = 2'b00;
      cyc(1'($urandom_range(0, 9) < 7), $urandom,
          1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 31)), ad, op,
          1'($urandom_range(0, 9) < 4), $urandom);
      tick();
    end
    idle(1, $urandom);
    tick();

    // reset while a load is waiting
    cyc(1, 32'hBFC0_0300, 1, 6, 32'h4000_0000, 5, 0, 0);
    tick();
    idle(0, 0);
    chk("wait_allowin", {31'd0, bus.wb_allowin}, 32'd0);
    tick();
    do_reset();
    idle(1, 32'h1234_5678);
    chk("post_rst_we", {31'd0, rf_we}, 32'd0);
    tick();
    idle(0, 0);
    chk("post_rst_cnt", retire_cnt, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
